// File: rtl/serializer_bank.sv
// ---------------------------------------------------------------------------
// serializer_bank
//   Multi-lane parallel-to-serial shifter. One WIDTH-bit word per lane is
//   captured through a valid/ready handshake and shifted out one bit per
//   enabled cycle on all lanes in lockstep. Back-to-back words are gap-free:
//   the next word is accepted on the same edge that consumes the last bit.
//
// Parameters
//   WIDTH     bits per word per lane (>= 2)
//   CHANNELS  number of serial lanes (>= 1)
//   MSB_FIRST 0: bit 0 leaves first, 1: bit WIDTH-1 leaves first
//
// Ports
//   clk, rst   clock and synchronous active-high reset
//   in_data    lane c word = in_data[c*WIDTH +: WIDTH]
//   in_valid   source has a word
//   in_ready   block takes the word at this edge
//   ser_en     sink takes the current bit at this edge (0 = stall)
//   flush      drop the word in flight and return to IDLE
//   ser_out    current bit per lane (0 when ser_valid=0)
//   ser_valid  a bit is being presented
//   ser_last   the presented bit is the final one of the word
//   busy       a word is in flight
//   done       one-cycle pulse after a word has been fully consumed
// ---------------------------------------------------------------------------
module serializer_bank #(
    parameter int WIDTH     = 128,
    parameter int CHANNELS  = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      ser_en,
    input  logic                      flush,
    output logic [CHANNELS-1:0]       ser_out,
    output logic                      ser_valid,
    output logic                      ser_last,
    output logic                      busy,
    output logic                      done
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                            state_q, state_d;
    logic   [CW-1:0]                   cnt_q, cnt_d;
    logic   [CHANNELS-1:0][WIDTH-1:0]  sreg_q, sreg_d;
    logic                              done_q, done_d;

    logic at_last;
    logic accept;

    // cnt_q is the index of the bit currently on ser_out.
    assign at_last  = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    // In SHIFT a new word is only taken when the last bit leaves at this edge,
    // which is what makes back-to-back words bubble-free.
    assign in_ready = !rst && !flush && ((state_q == IDLE) || (at_last && ser_en));
    assign accept   = in_valid && in_ready;

    // State register (with datapath flops).
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift registers are reset too, so a dropped word can
            // never leak onto ser_out and the reset state is fully defined.
            state_q <= IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (accept) state_d = SHIFT;
                SHIFT: if (at_last && ser_en && !accept) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: load, shift, or clear.
    always_comb begin
        cnt_d  = cnt_q;
        sreg_d = sreg_q;
        done_d = 1'b0;
        if (flush) begin
            cnt_d  = '0;
            sreg_d = '0;
        end else if (accept) begin
            // Accept in SHIFT only happens while the last bit is consumed.
            sreg_d = in_data;
            cnt_d  = '0;
            done_d = at_last;
        end else if ((state_q == SHIFT) && ser_en) begin
            if (at_last) begin
                cnt_d  = '0;
                sreg_d = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                for (int c = 0; c < CHANNELS; c++) begin
                    if (MSB_FIRST) sreg_d[c] = sreg_q[c] << 1;
                    else           sreg_d[c] = sreg_q[c] >> 1;
                end
            end
        end
    end

    // Output logic.
    always_comb begin
        ser_valid = (state_q == SHIFT);
        busy      = (state_q == SHIFT);
        ser_last  = at_last;
        done      = done_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (MSB_FIRST) ser_out[c] = ser_valid && sreg_q[c][WIDTH-1];
            else           ser_out[c] = ser_valid && sreg_q[c][0];
        end
    end

endmodule

// File: tb/tb_serializer_bank.sv
// ---------------------------------------------------------------------------
// tb_serializer_bank
//   Drives an LSB-first and an MSB-first 8x2 instance with identical stimulus
//   and compares both against a word/bit-index reference model every cycle,
//   plus a 128x2 instance for walking-ones words.
// ---------------------------------------------------------------------------
module tb_serializer_bank;

    localparam int W  = 8;
    localparam int C  = 2;
    localparam int WW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, in_valid, ser_en, flush;
    logic [C*W-1:0] in_data;

    logic         l_ready, l_valid, l_last, l_busy, l_done;
    logic [C-1:0] l_out;
    logic         m_ready, m_valid, m_last, m_busy, m_done;
    logic [C-1:0] m_out;

    logic [C*WW-1:0] w_in_data;
    logic            w_in_valid;
    logic            w_ready, w_valid, w_last, w_busy, w_done;
    logic [C-1:0]    w_out;

    serializer_bank #(.WIDTH(W), .CHANNELS(C), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_ready), .ser_en(ser_en), .flush(flush), .ser_out(l_out),
        .ser_valid(l_valid), .ser_last(l_last), .busy(l_busy), .done(l_done)
    );

    serializer_bank #(.WIDTH(W), .CHANNELS(C), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(m_ready), .ser_en(ser_en), .flush(flush), .ser_out(m_out),
        .ser_valid(m_valid), .ser_last(m_last), .busy(m_busy), .done(m_done)
    );

    serializer_bank u_wide (
        .clk(clk), .rst(rst), .in_data(w_in_data), .in_valid(w_in_valid),
        .in_ready(w_ready), .ser_en(ser_en), .flush(flush), .ser_out(w_out),
        .ser_valid(w_valid), .ser_last(w_last), .busy(w_busy), .done(w_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the word being sent and the index of the bit on the wire.
    bit         m_known  = 1'b0;
    bit         mdl_busy = 1'b0;
    int         mdl_idx  = 0;
    bit         mdl_done = 1'b0;
    bit         mdl_acc  = 1'b0;
    logic [W-1:0] mdl_word [C];

    // Values observed in the most recent tick (sampled at the negedge).
    logic         o_ready, o_valid, o_last, o_done;
    logic [C-1:0] o_out_l, o_out_m;
    logic         o_w_valid;
    logic [C-1:0] o_w_out;

    function automatic logic exp_bit(input logic [W-1:0] w, input int idx, input bit msb);
        return msb ? w[W-1-idx] : w[idx];
    endfunction

    // One clock: check outputs against the model, then advance the model
    // with the inputs that the coming posedge will see.
    task automatic tick();
        logic         exp_ready;
        logic [C-1:0] eo_l, eo_m;
        bit           nd;
        @(negedge clk);
        exp_ready = !rst && !flush && (!mdl_busy || (mdl_idx == W-1 && ser_en));
        check("in_ready_lsb", l_ready, exp_ready);
        check("in_ready_msb", m_ready, exp_ready);
        if (m_known) begin
            for (int c = 0; c < C; c++) begin
                eo_l[c] = mdl_busy && exp_bit(mdl_word[c], mdl_idx, 1'b0);
                eo_m[c] = mdl_busy && exp_bit(mdl_word[c], mdl_idx, 1'b1);
            end
            check("ser_out_lsb", l_out, eo_l);
            check("ser_out_msb", m_out, eo_m);
            check("ser_valid_lsb", l_valid, mdl_busy);
            check("ser_valid_msb", m_valid, mdl_busy);
            check("busy_lsb", l_busy, mdl_busy);
            check("ser_last_lsb", l_last, mdl_busy && mdl_idx == W-1);
            check("ser_last_msb", m_last, mdl_busy && mdl_idx == W-1);
            check("done_lsb", l_done, mdl_done);
            check("done_msb", m_done, mdl_done);
        end
        o_ready = l_ready; o_valid = l_valid; o_last = l_last; o_done = l_done;
        o_out_l = l_out;   o_out_m = m_out;
        o_w_valid = w_valid; o_w_out = w_out;

        mdl_acc = in_valid && exp_ready;
        if (rst) begin
            m_known = 1'b1; mdl_busy = 1'b0; mdl_idx = 0; mdl_done = 1'b0;
        end else if (flush) begin
            mdl_busy = 1'b0; mdl_idx = 0; mdl_done = 1'b0;
        end else begin
            nd = 1'b0;
            if (mdl_busy && ser_en) begin
                if (mdl_idx == W-1) begin
                    nd = 1'b1;
                    mdl_idx = 0;
                    if (mdl_acc) for (int c = 0; c < C; c++) mdl_word[c] = in_data[c*W +: W];
                    else         mdl_busy = 1'b0;
                end else begin
                    mdl_idx++;
                end
            end else if (!mdl_busy && mdl_acc) begin
                for (int c = 0; c < C; c++) mdl_word[c] = in_data[c*W +: W];
                mdl_busy = 1'b1;
                mdl_idx  = 0;
            end
            mdl_done = nd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [C*W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [W-1:0] col0, col1, colm0, colm1;
    int           n, last_at, done_at, d1, d2, vrun, maxrun, bad_ready;
    int           ones0, ones1, pos0, pos1;
    int           ks [6] = '{0, 1, 63, 64, 126, 127};

    initial begin
        rst = 1'b1; in_valid = 1'b0; ser_en = 1'b1; flush = 1'b0;
        in_data = '0; w_in_data = '0; w_in_valid = 1'b0;
        for (int c = 0; c < C; c++) mdl_word[c] = '0;
        tick();
        rst = 1'b0;
        tick();

        // Test 1: LSB/MSB ordering, last and done timing.
        load_word({8'hA5, 8'h3C});
        col0 = '0; col1 = '0; colm0 = '0; colm1 = '0; n = 0; last_at = -1; done_at = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_valid && n < W) begin
                col0[n] = o_out_l[0]; col1[n] = o_out_l[1];
                colm0[W-1-n] = o_out_m[0]; colm1[W-1-n] = o_out_m[1];
                n++;
            end
            if (o_last) last_at = i;
            if (o_done) done_at = i;
        end
        check("t1_lane0", col0, 8'h3C);
        check("t1_lane1", col1, 8'hA5);
        check("t1_msb_lane0", colm0, 8'h3C);
        check("t1_msb_lane1", colm1, 8'hA5);
        check("t1_nbits", n, W);
        check("t1_last_at", last_at, 7);
        check("t1_done_at", done_at, 8);

        // Test 2: MSB-first sends bit 7 first.
        load_word({8'h00, 8'h80});
        tick();
        check("t2_first_msb", o_out_m[0], 1'b1);
        check("t2_first_lsb", o_out_l[0], 1'b0);
        for (int i = 0; i < 9; i++) tick();

        // Test 3: back-to-back words with in_valid held.
        in_data = 16'hFFFF; in_valid = 1'b1;
        tick();
        in_data = 16'h0000;
        vrun = 0; maxrun = 0; d1 = -1; d2 = -1; bad_ready = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vrun = o_valid ? vrun + 1 : 0;
            if (vrun > maxrun) maxrun = vrun;
            if (o_ready && o_valid && !o_last) bad_ready++;
            if (o_done) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
            if (mdl_acc) in_valid = 1'b0;
        end
        check("t3_valid_run", maxrun, 16);
        check("t3_done_gap", d2 - d1, 8);
        check("t3_ready_only_last", bad_ready, 0);

        // Test 4: three-cycle stall at cnt=4.
        load_word({8'hA5, 8'h3C});
        col0 = '0; col1 = '0; n = 0; last_at = -1; done_at = -1;
        for (int i = 0; i < 15; i++) begin
            ser_en = !(i >= 4 && i <= 6);
            tick();
            if (o_valid && ser_en && n < W) begin
                col0[n] = o_out_l[0]; col1[n] = o_out_l[1]; n++;
            end
            if (o_last && last_at < 0) last_at = i;
            if (o_done) done_at = i;
        end
        ser_en = 1'b1;
        check("t4_lane0", col0, 8'h3C);
        check("t4_lane1", col1, 8'hA5);
        check("t4_last_at", last_at, 10);
        check("t4_done_at", done_at, 11);

        // Test 5: flush at cnt=3 while a new word is offered.
        load_word({8'hA5, 8'h3C});
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        tick();
        check("t5_flush_ready", o_ready, 1'b0);
        flush = 1'b0;
        tick();
        check("t5_idle_valid", o_valid, 1'b0);
        check("t5_no_done", o_done, 1'b0);
        check("t5_fresh_ready", o_ready, 1'b1);
        if (mdl_acc) in_valid = 1'b0;
        tick();
        check("t5_fresh_valid", o_valid, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Test 6: reset mid-word at cnt=5.
        load_word({8'hFF, 8'hFF});
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t6_valid", o_valid, 1'b0);
        check("t6_out", o_out_l, 2'b00);
        check("t6_last", o_last, 1'b0);
        check("t6_done", o_done, 1'b0);
        check("t6_ready", o_ready, 1'b1);

        // Randomized traffic: source holds data until accepted.
        for (int i = 0; i < 1500; i++) begin
            if (!in_valid && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b1;
                in_data  = 16'($urandom());
            end
            ser_en = ($urandom_range(0, 4) != 0);
            flush  = ($urandom_range(0, 40) == 0);
            rst    = ($urandom_range(0, 150) == 0);
            tick();
            if (mdl_acc) in_valid = 1'b0;
        end
        rst = 1'b0; flush = 1'b1; ser_en = 1'b1; in_valid = 1'b0;
        tick();
        flush = 1'b0;
        tick();

        // Default parameters: walking ones on a 128-bit word.
        foreach (ks[j]) begin
            w_in_data = '0;
            w_in_data[ks[j]] = 1'b1;
            w_in_data[WW + (WW - 1 - ks[j])] = 1'b1;
            w_in_valid = 1'b1;
            tick();
            w_in_valid = 1'b0;
            ones0 = 0; ones1 = 0; pos0 = -1; pos1 = -1; n = 0;
            for (int i = 0; i < WW + 2; i++) begin
                tick();
                if (o_w_valid) begin
                    if (o_w_out[0]) begin ones0++; pos0 = n; end
                    if (o_w_out[1]) begin ones1++; pos1 = n; end
                    n++;
                end
            end
            check("wide_nbits", n, WW);
            check("wide_ones0", ones0, 1);
            check("wide_pos0", pos0, ks[j]);
            check("wide_ones1", ones1, 1);
            check("wide_pos1", pos1, WW - 1 - ks[j]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
